// File: rtl/ef_i2s_pkg.sv
// Shared constants and types for the I2S sample packer slice.
package ef_i2s_pkg;

    localparam int SAMPLE_W = 32;
    localparam int HALF_W   = 16;

    localparam logic signed [HALF_W-1:0] SAT16_MAX = 16'sh7FFF;
    localparam logic signed [HALF_W-1:0] SAT16_MIN = 16'sh8000;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [HALF_W-1:0]   half_t;

endpackage

// File: rtl/ef_i2s_sat16.sv
// 32-bit sample to 16-bit half-word conversion for pack16 mode.
// Build option: define EF_I2S_PACK_SAT16_EN for signed saturation to
// [-32768, 32767]; otherwise the upper 16 bits are simply dropped.
module ef_i2s_sat16
    import ef_i2s_pkg::*;
(
    input  logic [SAMPLE_W-1:0] din,
    output logic [HALF_W-1:0]   dout
);

`ifdef EF_I2S_PACK_SAT16_EN
    // The sample fits in 16 signed bits when bits [31:15] are all copies of the sign
    logic in_range;
    assign in_range = (din[SAMPLE_W-1:HALF_W-1] == {(SAMPLE_W-HALF_W+1){din[HALF_W-1]}});

    // Clamp out-of-range samples toward the sign of the original value
    always_comb begin
        if (in_range) begin
            dout = din[HALF_W-1:0];
        end else if (din[SAMPLE_W-1]) begin
            dout = SAT16_MIN;
        end else begin
            dout = SAT16_MAX;
        end
    end
`else
    // Truncation: upper bits are intentionally discarded
    logic unused_hi;
    assign unused_hi = ^din[SAMPLE_W-1:HALF_W];
    assign dout      = din[HALF_W-1:0];
`endif

endmodule

// File: rtl/ef_i2s_sample_packer.sv
// Drains the I2S RX sample FIFO into a 32-bit valid/ready stream, either one
// sample per word or two 16-bit half-words per word, and tags frame ends.
// Build option: EF_I2S_PACK_SAT16_EN selects saturating half-word conversion.
module ef_i2s_sample_packer
    import ef_i2s_pkg::*;
#(
    parameter int FLW = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                flush,
    input  logic                pack16,
    input  logic [FLW-1:0]      frame_len,
    input  logic                fifo_empty,
    input  logic [SAMPLE_W-1:0] fifo_rdata,
    output logic                fifo_rd,
    output logic [SAMPLE_W-1:0] m_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                m_last,
    output logic [FLW-1:0]      frame_cnt
);

    logic                         have_lo;
    logic [HALF_W-1:0]            lo_reg;
    logic                         mode_r;
    logic                         mode_nx;
    logic                         pop;
    logic                         load;
    logic                         last_hit;
    logic [SAMPLE_W-1:0]          word_next;
    logic [1:0][HALF_W-1:0]       half_w;

    // Index 0 feeds the held low half, index 1 the upper half of a packed word
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_half
            ef_i2s_sat16 u_sat16 (
                .din  (fifo_rdata),
                .dout (half_w[gi])
            );
        end
    endgenerate

    // A half-word in flight pins the mode so a pack16 toggle cannot split a word
    assign mode_nx = have_lo ? mode_r : pack16;

    // A low-half pop never touches the output register, so it may proceed under backpressure
    assign pop = rst_n & en & ~flush & ~fifo_empty &
                 ((mode_nx & ~have_lo) | ~m_valid | m_ready);

    assign fifo_rd   = pop;
    assign load      = pop & (~mode_nx | have_lo);
    assign word_next = mode_nx ? {half_w[1], lo_reg} : fifo_rdata;
    assign last_hit  = (frame_len != '0) && (frame_cnt == frame_len - FLW'(1));

    // Held half-word: captured on the first pop of a pack16 pair, released on the second
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            have_lo <= 1'b0;
            lo_reg  <= '0;
            mode_r  <= 1'b0;
        end else if (flush) begin
            have_lo <= 1'b0;
        end else if (pop && mode_nx && !have_lo) begin
            lo_reg  <= half_w[0];
            have_lo <= 1'b1;
            mode_r  <= 1'b1;
        end else if (load && have_lo) begin
            have_lo <= 1'b0;
        end
    end

    // Output register and frame counter; a load in the same cycle as a drain keeps m_valid high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data    <= '0;
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_cnt <= '0;
        end else if (flush) begin
            m_valid   <= 1'b0;
            m_last    <= 1'b0;
            frame_cnt <= '0;
        end else if (load) begin
            m_data    <= word_next;
            m_valid   <= 1'b1;
            m_last    <= last_hit;
            frame_cnt <= last_hit ? '0 : frame_cnt + FLW'(1);
        end else if (m_valid && m_ready) begin
            m_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ef_i2s_sample_packer.sv
// Self-checking bench for ef_i2s_sample_packer: directed table, hand-written
// corner sequences and randomized runs against a word-level reference model.
module tb_ef_i2s_sample_packer;

    localparam int FLW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic           flush;
    logic           pack16;
    logic [FLW-1:0] frame_len;
    logic           fifo_empty;
    logic [31:0]    fifo_rdata;
    logic           fifo_rd;
    logic [31:0]    m_data;
    logic           m_valid;
    logic           m_ready;
    logic           m_last;
    logic [FLW-1:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ef_i2s_sample_packer #(.FLW(FLW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .flush      (flush),
        .pack16     (pack16),
        .frame_len  (frame_len),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd    (fifo_rd),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last),
        .frame_cnt  (frame_cnt)
    );

    // Show-ahead FIFO model
    logic [31:0] fmem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    always @(posedge clk) if (fifo_rd) rd_ptr <= rd_ptr + 1;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = fifo_empty ? 32'h0 : fmem[rd_ptr % 4096];

    // Collected output words {last, data} and pop count
    logic [32:0] out_q [$];
    int          pops = 0;
    logic        hold_prev = 1'b0;
    logic [31:0] data_prev = '0;
    logic        last_prev = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: count pops, capture handshakes, check stability under backpressure
    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_rd) pops <= pops + 1;
            if (m_valid && m_ready) out_q.push_back({m_last, m_data});
            if (hold_prev) begin
                chk("hold_valid", m_valid, 1);
                chk("hold_data", m_data, data_prev);
                chk("hold_last", m_last, last_prev);
            end
            hold_prev <= m_valid && !m_ready && !flush;
            data_prev <= m_data;
            last_prev <= m_last;
        end else begin
            hold_prev <= 1'b0;
        end
    end

    function automatic logic [15:0] ref_half(input logic [31:0] x);
`ifdef EF_I2S_PACK_SAT16_EN
        longint s;
        s = longint'($signed(x));
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return x[15:0];
`else
        return x[15:0];
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        fmem[wr_ptr % 4096] = d;
        wr_ptr++;
    endtask

    task automatic wait_words(input int n, input int budget, input string name);
        int c;
        c = 0;
        while (out_q.size() < n && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_timeout"}, out_q.size() >= n, 1);
    endtask

    task automatic wait_pops(input int target, input int budget, input string name);
        int c;
        c = 0;
        while (pops < target && c < budget) begin
            tick();
            c++;
        end
        chk({name, "_pop_timeout"}, pops >= target, 1);
    endtask

    task automatic do_flush(input string name);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk({name, "_flush_valid"}, m_valid, 0);
        chk({name, "_flush_cnt"}, frame_cnt, 0);
        tick();
    endtask

    typedef struct {
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] exp_trunc;
        logic [31:0] exp_sat;
    } pk_vec_t;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        pk_vec_t     vt [5];
        logic [31:0] pt_d [5];
        logic        pt_v [5];
        logic        pt_r [5];
        logic [31:0] d0;
        logic [32:0] exp_q [$];
        logic [31:0] smp [$];
        int          p0, nlast, pk, fl, n, sent, nw;

        vt[0] = '{32'h0000_1234, 32'h0000_ABCD, 32'hABCD_1234, 32'h7FFF_1234};
        vt[1] = '{32'h0001_0000, 32'hFFFE_0000, 32'h0000_0000, 32'h8000_7FFF};
        vt[2] = '{32'hFFFF_8000, 32'h0000_7FFF, 32'h7FFF_8000, 32'h7FFF_8000};
        vt[3] = '{32'h1234_5678, 32'h9ABC_DEF0, 32'hDEF0_5678, 32'h8000_7FFF};
        vt[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_FFFF, 32'h0000_FFFF};

        // Reset: outputs at reset values and no pop while rst_n is low
        rst_n = 1'b0; en = 1'b1; flush = 1'b0; pack16 = 1'b0;
        frame_len = '0; m_ready = 1'b1;
        push(32'h11); push(32'h22); push(32'h33);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_data", m_data, 0);
        chk("rst_last", m_last, 0);
        chk("rst_cnt", frame_cnt, 0);
        chk("rst_rd", fifo_rd, 0);
        rst_n = 1'b1;

        // Pass-through, back to back
        pt_r = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        pt_v = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        pt_d = '{32'h0, 32'h11, 32'h22, 32'h33, 32'h0};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk($sformatf("pt_rd%0d", c), fifo_rd, pt_r[c]);
            chk($sformatf("pt_valid%0d", c), m_valid, pt_v[c]);
            if (pt_v[c]) chk($sformatf("pt_data%0d", c), m_data, pt_d[c]);
            tick();
        end

        // Pack16 table
        pack16 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            out_q.delete();
            p0 = pops;
            push(vt[i].s0); push(vt[i].s1);
            wait_words(1, 20, $sformatf("pk%0d", i));
            repeat (3) tick();
`ifdef EF_I2S_PACK_SAT16_EN
            chk($sformatf("pk%0d_data", i), out_q[0][31:0], vt[i].exp_sat);
`else
            chk($sformatf("pk%0d_data", i), out_q[0][31:0], vt[i].exp_trunc);
`endif
            chk($sformatf("pk%0d_words", i), out_q.size(), 1);
            chk($sformatf("pk%0d_pops", i), pops - p0, 2);
        end

        // Backpressure in pack16: only the next low half may be popped
        do_flush("bp");
        out_q.delete();
        p0 = pops;
        m_ready = 1'b0;
        push(32'h0101); push(32'h0202); push(32'h0303); push(32'h0404);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (m_valid) break;
            tick();
        end
        chk("bp_valid", m_valid, 1);
        d0 = m_data;
        chk("bp_first", d0, 32'h0202_0101);
        for (int c = 0; c < 5; c++) begin
            tick();
            @(negedge clk);
            chk("bp_stable", m_data, d0);
        end
        chk("bp_pops", pops - p0, 3);
        tick();
        m_ready = 1'b1;
        wait_words(2, 20, "bp");
        repeat (3) tick();
        chk("bp_w0", out_q[0][31:0], 32'h0202_0101);
        chk("bp_w1", out_q[1][31:0], 32'h0404_0303);
        chk("bp_count", out_q.size(), 2);

        // Framing with frame_len=3 over 7 words
        do_flush("fr");
        pack16 = 1'b0;
        frame_len = 8'd3;
        out_q.delete();
        for (int i = 0; i < 7; i++) push(32'h100 + i);
        wait_words(7, 40, "fr");
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("fr_last%0d", i + 1), out_q[i][32], (i == 2 || i == 5));
            chk($sformatf("fr_data%0d", i + 1), out_q[i][31:0], 32'h100 + i);
        end
        chk("fr_cnt_end", frame_cnt, 1);

        // Unframed: never m_last
        do_flush("uf");
        frame_len = '0;
        out_q.delete();
        for (int i = 0; i < 5; i++) push(32'h200 + i);
        wait_words(5, 40, "uf");
        nlast = 0;
        for (int i = 0; i < 5; i++) if (out_q[i][32]) nlast++;
        chk("uf_nolast", nlast, 0);
        chk("uf_cnt", frame_cnt, 5);

        // Flush while holding a half-word and a pending word
        do_flush("fl");
        pack16 = 1'b1;
        m_ready = 1'b0;
        p0 = pops;
        push(32'h0A0A); push(32'h0B0B); push(32'h0C0C);
        wait_pops(p0 + 3, 20, "fl");
        tick();
        chk("fl_pre_valid", m_valid, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_valid", m_valid, 0);
        chk("fl_cnt", frame_cnt, 0);
        tick();
        out_q.delete();
        m_ready = 1'b1;
        push(32'h0D0D); push(32'h0E0E);
        wait_words(1, 20, "fl");
        repeat (3) tick();
        chk("fl_fresh", out_q[0][31:0], 32'h0E0E_0D0D);
        chk("fl_count", out_q.size(), 1);

        // Async reset mid-frame with a held half and a pending word
        m_ready = 1'b0;
        p0 = pops;
        push(32'h0111); push(32'h0222); push(32'h0333);
        wait_pops(p0 + 3, 20, "ar");
        tick();
        push(32'h0444);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", m_valid, 0);
        chk("ar_data", m_data, 0);
        chk("ar_cnt", frame_cnt, 0);
        chk("ar_rd", fifo_rd, 0);
        tick();
        rst_n = 1'b1;
        out_q.delete();
        m_ready = 1'b1;
        push(32'h0555);
        wait_words(1, 20, "ar");
        repeat (3) tick();
        chk("ar_fresh", out_q[0][31:0], 32'h0555_0444);
        chk("ar_count", out_q.size(), 1);

        // Randomized runs against the word-level model
        for (int run = 0; run < 8; run++) begin
            en = 1'b0;
            m_ready = 1'b1;
            do_flush($sformatf("rnd%0d", run));
            pk = int'($urandom_range(0, 1));
            fl = int'($urandom_range(0, 4));
            n  = 2 * int'($urandom_range(4, 20));
            pack16 = pk[0];
            frame_len = FLW'(fl);
            smp.delete();
            exp_q.delete();
            for (int i = 0; i < n; i++) begin
                case ($urandom_range(0, 3))
                    0: smp.push_back($urandom);
                    1: smp.push_back(32'($urandom_range(0, 32767)));
                    2: smp.push_back(32'hFFFF_8000 + 32'($urandom_range(0, 32767)));
                    default: smp.push_back($urandom_range(0, 1) != 0 ? 32'h0000_8000 : 32'hFFFF_7FFF);
                endcase
            end
            nw = (pk != 0) ? n / 2 : n;
            for (int k = 0; k < nw; k++) begin
                logic [31:0] w;
                logic        l;
                w = (pk != 0) ? {ref_half(smp[2*k+1]), ref_half(smp[2*k])} : smp[k];
                l = (fl != 0) && ((k % fl) == fl - 1);
                exp_q.push_back({l, w});
            end
            out_q.delete();
            sent = 0;
            for (int cyc = 0; cyc < 3000 && out_q.size() < nw; cyc++) begin
                if (sent < n && $urandom_range(0, 2) != 0) begin
                    push(smp[sent]);
                    sent++;
                end
                en = ($urandom_range(0, 3) != 0);
                m_ready = ($urandom_range(0, 4) > 1);
                tick();
            end
            chk($sformatf("rnd%0d_timeout", run), out_q.size() >= nw, 1);
            en = 1'b1;
            m_ready = 1'b1;
            repeat (4) tick();
            chk($sformatf("rnd%0d_count", run), out_q.size(), nw);
            for (int k = 0; k < nw && k < out_q.size(); k++)
                chk($sformatf("rnd%0d_w%0d", run, k), out_q[k], exp_q[k]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
